// File: rtl/pci_fifo_arbiter.sv
// First-come-first-served PCI bus arbiter: queues active-low REQ# lines in arrival
// order and drives one active-low GNT# at a time, following FRAME#/IRDY# ownership.

module pci_fifo_arbiter_lane (
   input  logic clk,
   input  logic reset,
   input  logic req_n,
   input  logic owner_hit,
   input  logic pop_clr,
   output logic push
);
   logic pending_d, pending_q;

   // A requester already queued or currently owning the bus is not pushed again.
   always_comb begin
      push      = !req_n && !pending_q && !owner_hit;
      pending_d = (pending_q || push) && !pop_clr;
   end

   always_ff @(posedge clk) begin
      if (reset) pending_q <= 1'b0;
      else       pending_q <= pending_d;
   end
endmodule

module pci_fifo_arbiter #(
   parameter int NREQ        = 8,
   parameter int GNT_TIMEOUT = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NREQ-1:0] req_n,
   input  logic            frame_n,
   input  logic            irdy_n,
   output logic [NREQ-1:0] gnt_n,
   output logic [2:0]      owner,
   output logic            owner_valid,
   output logic [3:0]      q_count
);
   localparam int TW = (GNT_TIMEOUT > 16) ? $clog2(GNT_TIMEOUT) : 4;
   localparam logic [TW-1:0] TMO_LAST = TW'(GNT_TIMEOUT - 1);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_GRANTED = 2'd1;
   localparam logic [1:0] ST_BUSY    = 2'd2;

   logic [NREQ-1:0][2:0] fifo_d, fifo_q;
   logic [2:0]           head_d, head_q, tail_d, tail_q, wr_ptr, head_id;
   logic [3:0]           count_d, count_q, n_push;
   logic [1:0]           state_d, state_q;
   logic [NREQ-1:0]      gnt_d, gnt_q;
   logic [2:0]           owner_d, owner_q;
   logic                 owner_valid_d, owner_valid_q;
   logic [TW-1:0]        tmo_d, tmo_q;
   logic [NREQ-1:0]      owner_hit, pop_clr, push;
   logic                 pop;

   always_comb begin
      owner_hit = '0;
      if (owner_valid_q) owner_hit = NREQ'(1) << owner_q;
      head_id = fifo_q[head_q];
      pop     = (state_q == ST_IDLE) && (count_q != 4'd0);
      pop_clr = '0;
      if (pop) pop_clr = NREQ'(1) << head_id;
   end

   pci_fifo_arbiter_lane u_lane [NREQ-1:0] (
      .clk       (clk),
      .reset     (reset),
      .req_n     (req_n),
      .owner_hit (owner_hit),
      .pop_clr   (pop_clr),
      .push      (push)
   );

   // Same-cycle arrivals are appended in ascending id order behind existing entries.
   always_comb begin
      fifo_d = fifo_q;
      wr_ptr = tail_q;
      n_push = 4'd0;
      for (int i = 0; i < NREQ; i++) begin
         if (push[i]) begin
            fifo_d[wr_ptr] = 3'(i);
            wr_ptr         = wr_ptr + 3'd1;
            n_push         = n_push + 4'd1;
         end
      end
      tail_d  = wr_ptr;
      head_d  = pop ? head_q + 3'd1 : head_q;
      count_d = count_q + n_push - {3'd0, pop};
   end

   always_comb begin
      state_d       = state_q;
      gnt_d         = gnt_q;
      owner_d       = owner_q;
      owner_valid_d = owner_valid_q;
      tmo_d         = tmo_q;
      case (state_q)
         ST_IDLE: begin
            gnt_d = '1;
            // A popped head whose REQ# has gone away is dropped; that costs one cycle.
            if (pop && !req_n[head_id]) begin
               state_d       = ST_GRANTED;
               gnt_d         = ~(NREQ'(1) << head_id);
               owner_d       = head_id;
               owner_valid_d = 1'b1;
               tmo_d         = '0;
            end
         end
         ST_GRANTED: begin
            if (!frame_n) begin
               state_d = ST_BUSY;
            end else if (req_n[owner_q] || tmo_q == TMO_LAST) begin
               state_d       = ST_IDLE;
               gnt_d         = '1;
               owner_d       = 3'd0;
               owner_valid_d = 1'b0;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         ST_BUSY: begin
            if (frame_n && irdy_n) begin
               state_d       = ST_IDLE;
               gnt_d         = '1;
               owner_d       = 3'd0;
               owner_valid_d = 1'b0;
            end else if (count_q != 4'd0) begin
               // Someone is waiting: withdraw GNT# so the master stops after this transaction.
               gnt_d = '1;
            end
         end
         default: begin
            state_d       = ST_IDLE;
            gnt_d         = '1;
            owner_d       = 3'd0;
            owner_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fifo_q        <= '0;
         head_q        <= '0;
         tail_q        <= '0;
         count_q       <= '0;
         state_q       <= ST_IDLE;
         gnt_q         <= '1;
         owner_q       <= '0;
         owner_valid_q <= 1'b0;
         tmo_q         <= '0;
      end else begin
         fifo_q        <= fifo_d;
         head_q        <= head_d;
         tail_q        <= tail_d;
         count_q       <= count_d;
         state_q       <= state_d;
         gnt_q         <= gnt_d;
         owner_q       <= owner_d;
         owner_valid_q <= owner_valid_d;
         tmo_q         <= tmo_d;
      end
   end

   assign gnt_n       = gnt_q;
   assign owner       = owner_q;
   assign owner_valid = owner_valid_q;
   assign q_count     = count_q;
endmodule

// File: tb/tb_pci_fifo_arbiter.sv
// Bench for pci_fifo_arbiter: expected grant order is queued by the stimulus and
// checked by a monitor on every new grant; timing and queue depth are checked inline.
module tb_pci_fifo_arbiter;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] req_n = 8'hFF;
   logic       frame_n = 1'b1;
   logic       irdy_n = 1'b1;
   logic [7:0] gnt_n;
   logic [2:0] owner;
   logic       owner_valid;
   logic [3:0] q_count;

   int checks = 0;
   int errors = 0;
   logic [2:0] exp_q[$];

   always #5 clk = ~clk;

   pci_fifo_arbiter dut (
      .clk         (clk),
      .reset       (reset),
      .req_n       (req_n),
      .frame_n     (frame_n),
      .irdy_n      (irdy_n),
      .gnt_n       (gnt_n),
      .owner       (owner),
      .owner_valid (owner_valid),
      .q_count     (q_count)
   );

   function automatic logic [7:0] gnt_of(input logic [2:0] id);
      logic [7:0] v;
      v = 8'h01 << id;
      return ~v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // Monitor: each new grant must follow an all-high cycle and match the next expected id.
   initial begin
      logic [7:0] prev;
      logic [2:0] e;
      prev = 8'hFF;
      forever begin
         @(posedge clk);
         #1;
         if (gnt_n !== prev && gnt_n !== 8'hFF) begin
            chk("gap_before_grant", prev, 8'hFF);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_grant actual=%h expected=none", gnt_n);
            end else begin
               e = exp_q.pop_front();
               chk("grant_gnt", gnt_n, gnt_of(e));
               chk("grant_owner", {owner_valid, owner}, {1'b1, e});
            end
         end
         prev = gnt_n;
      end
   end

   task automatic wait_gnt(input int id);
      int n;
      n = 0;
      while (gnt_n[id] !== 1'b0 && n < 64) begin
         @(negedge clk);
         n++;
      end
      if (gnt_n[id] !== 1'b0) begin
         checks++;
         errors++;
         $display("FAIL grant_wait id=%0d actual=%h expected=%h", id, gnt_n, gnt_of(3'(id)));
      end
   endtask

   // Master runs one transaction with FRAME# low for n cycles, dropping REQ# once granted.
   task automatic xact(input int id, input int n);
      req_n[id] = 1'b1;
      frame_n   = 1'b0;
      irdy_n    = 1'b0;
      repeat (n) @(negedge clk);
      frame_n = 1'b1;
      irdy_n  = 1'b1;
      @(negedge clk);
      chk("release_gnt", gnt_n, 8'hFF);
      chk("release_owner_valid", owner_valid, 1'b0);
   endtask

   initial begin
      int cnt;
      // reset and idle
      repeat (2) @(negedge clk);
      chk("reset_gnt", gnt_n, 8'hFF);
      chk("reset_state", {owner_valid, owner, q_count}, 8'h00);
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("idle", {gnt_n, owner_valid, q_count}, {8'hFF, 1'b0, 4'd0});
      end

      // single request latency
      exp_q.push_back(3'd2);
      req_n = 8'hFB;
      @(negedge clk);
      chk("lat_qcount", q_count, 4'd1);
      chk("lat_gnt_before", gnt_n, 8'hFF);
      @(negedge clk);
      chk("lat_gnt", gnt_n, 8'hFB);
      xact(2, 3);
      chk("lat_qcount_end", q_count, 4'd0);

      // arrival order 5,1,{3,6}
      exp_q.push_back(3'd5);
      exp_q.push_back(3'd1);
      exp_q.push_back(3'd3);
      exp_q.push_back(3'd6);
      req_n[5] = 1'b0;
      @(negedge clk);
      req_n[1] = 1'b0;
      @(negedge clk);
      req_n[3] = 1'b0;
      req_n[6] = 1'b0;
      wait_gnt(5);
      xact(5, 2);
      chk("order_qcount", q_count, 4'd3);
      wait_gnt(1); xact(1, 2);
      wait_gnt(3); xact(3, 2);
      wait_gnt(6); xact(6, 2);
      chk("order_qcount_end", q_count, 4'd0);

      // stale entry
      exp_q.push_back(3'd4);
      req_n[4] = 1'b0;
      @(negedge clk);
      req_n[2] = 1'b0;
      @(negedge clk);
      wait_gnt(4);
      xact(4, 2);
      chk("stale_qcount_before", q_count, 4'd1);
      req_n[2] = 1'b1;
      @(negedge clk);
      chk("stale_qcount_after", q_count, 4'd0);
      chk("stale_gnt", gnt_n, 8'hFF);
      repeat (4) @(negedge clk);
      chk("stale_no_grant", gnt_n, 8'hFF);

      // grant timeout
      exp_q.push_back(3'd7);
      exp_q.push_back(3'd0);
      req_n[7] = 1'b0;
      @(negedge clk);
      req_n[0] = 1'b0;
      @(negedge clk);
      wait_gnt(7);
      cnt = 0;
      while (gnt_n[7] === 1'b0 && cnt < 40) begin
         cnt++;
         @(negedge clk);
      end
      chk("timeout_len", cnt, 16);
      chk("timeout_owner_valid", owner_valid, 1'b0);
      req_n[7] = 1'b1;
      wait_gnt(0);
      xact(0, 2);
      chk("timeout_qcount_end", q_count, 4'd0);

      // all eight, reset while owner 2 is BUSY
      exp_q.push_back(3'd0);
      exp_q.push_back(3'd1);
      exp_q.push_back(3'd2);
      req_n = 8'h00;
      @(negedge clk);
      chk("all_qcount8", q_count, 4'd8);
      wait_gnt(0); xact(0, 2);
      chk("all_qcount7", q_count, 4'd7);
      wait_gnt(1); xact(1, 2);
      chk("all_qcount6", q_count, 4'd6);
      wait_gnt(2);
      req_n[2] = 1'b1;
      frame_n  = 1'b0;
      irdy_n   = 1'b0;
      repeat (2) @(negedge clk);
      chk("busy_owner", {owner_valid, owner}, {1'b1, 3'd2});
      chk("busy_gnt_withdrawn", gnt_n, 8'hFF);
      reset   = 1'b1;
      frame_n = 1'b1;
      irdy_n  = 1'b1;
      for (int i = 3; i < 8; i++) exp_q.push_back(3'(i));
      @(negedge clk);
      chk("midreset_gnt", gnt_n, 8'hFF);
      chk("midreset_state", {owner_valid, q_count}, 5'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("requeue_qcount", q_count, 4'd5);
      for (int i = 3; i < 8; i++) begin
         wait_gnt(i);
         xact(i, 2);
      end
      chk("final_qcount", q_count, 4'd0);
      repeat (3) @(negedge clk);
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
